// File: rtl/wb_arbiter.sv
// Purpose: round-robin arbiter that merges ALU and LSU writebacks onto a single register-file write port.
// Latency: 1 cycle from acceptance to o_wr. Backpressure: the losing requester keeps its ready low and
//   holds its request; i_hold blocks all acceptance and freezes the output. Optional bypass: WB_BYPASS_EN.
module wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_rd,
    input  logic [31:0] i_alu_data,
    output logic        o_alu_ready,
    input  logic        i_lsu_valid,
    input  logic [4:0]  i_lsu_rd,
    input  logic [31:0] i_lsu_data,
    output logic        o_lsu_ready,
    input  logic        i_hold,
    output logic        o_wr,
    output logic [4:0]  o_rd,
    output logic [31:0] o_write_data
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    output logic        o_fwd1_valid,
    output logic [31:0] o_fwd1_data,
    output logic        o_fwd2_valid,
    output logic [31:0] o_fwd2_data
`endif
);

    // ptr = 1 means the LSU is favoured on the next contended cycle.
    logic        ptr;
    // pend: the output register holds a write not yet issued.
    logic        pend;
    // stalled: the pending write was frozen by i_hold; its release cycle admits nothing new.
    logic        stalled;
    logic [4:0]  rd_q;
    logic [31:0] data_q;

    logic        can_accept;
    logic        accept;
    logic        issue;
    logic [4:0]  acc_rd;
    logic [31:0] acc_data;

    assign can_accept   = ~rst & ~i_hold & ~stalled;
    assign o_alu_ready  = can_accept & i_alu_valid & (~i_lsu_valid | ~ptr);
    assign o_lsu_ready  = can_accept & i_lsu_valid & (~i_alu_valid |  ptr);
    assign accept       = o_alu_ready | o_lsu_ready;
    assign acc_rd       = o_alu_ready ? i_alu_rd   : i_lsu_rd;
    assign acc_data     = o_alu_ready ? i_alu_data : i_lsu_data;

    // A pending write goes out whenever the output is not frozen and reset is not being applied.
    assign issue        = pend & ~i_hold & ~rst;
    assign o_wr         = issue;
    assign o_rd         = rd_q;
    assign o_write_data = data_q;

    // Output register, pending/stall flags and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= 1'b0;
            pend    <= 1'b0;
            stalled <= 1'b0;
            rd_q    <= 5'd0;
            data_q  <= 32'd0;
        end else begin
            if (accept) begin
                ptr <= o_alu_ready;
            end
            // Writes to x0 are consumed without touching the output register.
            if (accept && (acc_rd != 5'd0)) begin
                rd_q   <= acc_rd;
                data_q <= acc_data;
                pend   <= 1'b1;
            end else if (issue) begin
                pend   <= 1'b0;
            end
            if (pend && i_hold) begin
                stalled <= 1'b1;
            end else if (issue) begin
                stalled <= 1'b0;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the write sitting in the output register to decode-stage readers.
    always_comb begin
        o_fwd1_valid = 1'b0;
        o_fwd1_data  = 32'd0;
        o_fwd2_valid = 1'b0;
        o_fwd2_data  = 32'd0;
        if (pend && (i_rs1 != 5'd0) && (i_rs1 == rd_q)) begin
            o_fwd1_valid = 1'b1;
            o_fwd1_data  = data_q;
        end
        if (pend && (i_rs2 != 5'd0) && (i_rs2 == rd_q)) begin
            o_fwd2_valid = 1'b1;
            o_fwd2_data  = data_q;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Purpose: self-checking bench for wb_arbiter; expected writes are queued at acceptance and matched on o_wr.
// Latency: inputs driven 1 time unit after posedge, readies sampled mid-cycle, writes sampled on negedge.
// Backpressure: contention, hold and reset scenarios exercise ready deassertion; bypass tested under WB_BYPASS_EN.
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        i_alu_valid;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        o_alu_ready;
    logic        i_lsu_valid;
    logic [4:0]  i_lsu_rd;
    logic [31:0] i_lsu_data;
    logic        o_lsu_ready;
    logic        i_hold;
    logic        o_wr;
    logic [4:0]  o_rd;
    logic [31:0] o_write_data;
`ifdef WB_BYPASS_EN
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic        o_fwd1_valid;
    logic [31:0] o_fwd1_data;
    logic        o_fwd2_valid;
    logic [31:0] o_fwd2_data;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [36:0] sb_q[$];

    wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_alu_valid  (i_alu_valid),
        .i_alu_rd     (i_alu_rd),
        .i_alu_data   (i_alu_data),
        .o_alu_ready  (o_alu_ready),
        .i_lsu_valid  (i_lsu_valid),
        .i_lsu_rd     (i_lsu_rd),
        .i_lsu_data   (i_lsu_data),
        .o_lsu_ready  (o_lsu_ready),
        .i_hold       (i_hold),
        .o_wr         (o_wr),
        .o_rd         (o_rd),
        .o_write_data (o_write_data)
`ifdef WB_BYPASS_EN
        ,
        .i_rs1        (i_rs1),
        .i_rs2        (i_rs2),
        .o_fwd1_valid (o_fwd1_valid),
        .o_fwd1_data  (o_fwd1_data),
        .o_fwd2_valid (o_fwd2_valid),
        .o_fwd2_data  (o_fwd2_data)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        sb_q.push_back({rd, data});
    endtask

    // Scoreboard: every issued write must match the oldest expected one.
    always @(negedge clk) begin
        if (o_wr === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_wr", {31'd0, o_wr}, 32'd0);
            end else begin
                logic [36:0] e;
                e = sb_q.pop_front();
                check("wr_rd",   {27'd0, o_rd}, {27'd0, e[36:32]});
                check("wr_data", o_write_data, e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; i_hold = 1'b0;
        i_alu_valid = 1'b1; i_alu_rd = 5'd1; i_alu_data = 32'h1;
        i_lsu_valid = 1'b1; i_lsu_rd = 5'd2; i_lsu_data = 32'h2;
`ifdef WB_BYPASS_EN
        i_rs1 = 5'd0; i_rs2 = 5'd0;
`endif
        // Reset state, with requests present to confirm readies stay low.
        cyc(); cyc(); #3;
        check("rst_wr",      {31'd0, o_wr}, 32'd0);
        check("rst_rd",      {27'd0, o_rd}, 32'd0);
        check("rst_data",    o_write_data, 32'd0);
        check("rst_alu_rdy", {31'd0, o_alu_ready}, 32'd0);
        check("rst_lsu_rdy", {31'd0, o_lsu_ready}, 32'd0);

        // Contention straight after reset: ALU first, then LSU.
        cyc(); rst = 1'b0;
        i_alu_valid = 1'b1; i_alu_rd = 5'd3; i_alu_data = 32'h11;
        i_lsu_valid = 1'b1; i_lsu_rd = 5'd4; i_lsu_data = 32'h22;
        #3;
        check("c1_alu_rdy", {31'd0, o_alu_ready}, 32'd1);
        check("c1_lsu_rdy", {31'd0, o_lsu_ready}, 32'd0);
        push(5'd3, 32'h11);
        cyc(); #3;
        check("c2_alu_rdy", {31'd0, o_alu_ready}, 32'd0);
        check("c2_lsu_rdy", {31'd0, o_lsu_ready}, 32'd1);
        check("c2_wr",      {31'd0, o_wr}, 32'd1);
        push(5'd4, 32'h22);
        cyc(); i_alu_valid = 1'b0; i_lsu_valid = 1'b0; #3;
        check("c3_wr", {31'd0, o_wr}, 32'd1);

        // ALU only.
        cyc(); i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'hDEADBEEF; #3;
        check("alu_rdy", {31'd0, o_alu_ready}, 32'd1);
        push(5'd5, 32'hDEADBEEF);

        // Zero destination: accepted, never written.
        cyc(); i_alu_valid = 1'b0;
        i_lsu_valid = 1'b1; i_lsu_rd = 5'd0; i_lsu_data = 32'h55; #3;
        check("z_lsu_rdy", {31'd0, o_lsu_ready}, 32'd1);
        cyc(); i_lsu_valid = 1'b0; #3;
        check("z_wr", {31'd0, o_wr}, 32'd0);

        // Back-to-back LSU stream: one acceptance per cycle.
        for (int i = 0; i < 4; i++) begin
            cyc();
            i_lsu_valid = 1'b1; i_lsu_rd = 5'(10 + i); i_lsu_data = 32'h1000 + 32'(i); #3;
            check("st_rdy", {31'd0, o_lsu_ready}, 32'd1);
            push(5'(10 + i), 32'h1000 + 32'(i));
        end
        cyc(); i_lsu_valid = 1'b0; #3;
        check("st_last_wr", {31'd0, o_wr}, 32'd1);

        // Hold: the pending write waits; the release cycle admits nothing new.
        cyc(); i_alu_valid = 1'b1; i_alu_rd = 5'd7; i_alu_data = 32'h77; #3;
        check("h_alu_rdy", {31'd0, o_alu_ready}, 32'd1);
        push(5'd7, 32'h77);
        for (int i = 0; i < 3; i++) begin
            cyc(); i_alu_valid = 1'b0; i_hold = 1'b1;
            i_lsu_valid = 1'b1; i_lsu_rd = 5'd8; i_lsu_data = 32'h88; #3;
            check("h_wr",      {31'd0, o_wr}, 32'd0);
            check("h_lsu_rdy", {31'd0, o_lsu_ready}, 32'd0);
            check("h_rd_kept", {27'd0, o_rd}, 32'd7);
        end
        cyc(); i_hold = 1'b0; #3;
        check("hr_wr",      {31'd0, o_wr}, 32'd1);
        check("hr_lsu_rdy", {31'd0, o_lsu_ready}, 32'd0);
        cyc(); #3;
        check("ha_lsu_rdy", {31'd0, o_lsu_ready}, 32'd1);
        push(5'd8, 32'h88);
        cyc(); i_lsu_valid = 1'b0;

        // Reset right after acceptance discards the write and resets the pointer.
        cyc(); i_alu_valid = 1'b1; i_alu_rd = 5'd9; i_alu_data = 32'h99; #3;
        check("r_alu_rdy", {31'd0, o_alu_ready}, 32'd1);
        cyc(); i_alu_valid = 1'b0; rst = 1'b1; #3;
        check("r_wr", {31'd0, o_wr}, 32'd0);
        cyc(); rst = 1'b0; #3;
        check("r_wr2",  {31'd0, o_wr}, 32'd0);
        check("r_rd",   {27'd0, o_rd}, 32'd0);
        check("r_data", o_write_data, 32'd0);
        i_alu_valid = 1'b1; i_alu_rd = 5'd1; i_alu_data = 32'hA1;
        i_lsu_valid = 1'b1; i_lsu_rd = 5'd2; i_lsu_data = 32'hA2; #1;
        check("rp_alu_rdy", {31'd0, o_alu_ready}, 32'd1);
        check("rp_lsu_rdy", {31'd0, o_lsu_ready}, 32'd0);
        push(5'd1, 32'hA1);
        cyc(); #3;
        check("rp2_lsu_rdy", {31'd0, o_lsu_ready}, 32'd1);
        push(5'd2, 32'hA2);
        cyc(); i_alu_valid = 1'b0; i_lsu_valid = 1'b0;

`ifdef WB_BYPASS_EN
        // Forwarding from a held write, then from the issuing cycle, then none.
        cyc(); i_alu_valid = 1'b1; i_alu_rd = 5'd12; i_alu_data = 32'hCAFE; #3;
        push(5'd12, 32'hCAFE);
        cyc(); i_alu_valid = 1'b0; i_hold = 1'b1; i_rs1 = 5'd12; i_rs2 = 5'd0; #3;
        check("f1_vld",  {31'd0, o_fwd1_valid}, 32'd1);
        check("f1_dat",  o_fwd1_data, 32'hCAFE);
        check("f2_vld",  {31'd0, o_fwd2_valid}, 32'd0);
        check("f2_dat",  o_fwd2_data, 32'd0);
        i_rs2 = 5'd12; #1;
        check("f2_hit",  {31'd0, o_fwd2_valid}, 32'd1);
        cyc(); i_hold = 1'b0; #3;
        check("f_iss_wr",  {31'd0, o_wr}, 32'd1);
        check("f_iss_vld", {31'd0, o_fwd1_valid}, 32'd1);
        cyc(); #3;
        check("f_done_vld", {31'd0, o_fwd1_valid}, 32'd0);
        check("f_done_dat", o_fwd1_data, 32'd0);
        i_rs1 = 5'd0; i_rs2 = 5'd0;
`endif

        repeat (3) cyc();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL expose these ports (name  direction  width  meaning):
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- i_alu_valid  input  1  ALU writeback request.
- i_alu_rd  input  5  ALU destination register.
- i_alu_data  input  32  ALU result.
- o_alu_ready  output  1  ALU request accepted this cycle.
- i_lsu_valid  input  1  LSU writeback request.
- i_lsu_rd  input  5  LSU destination register.
- i_lsu_data  input  32  LSU load data.
- o_lsu_ready  output  1  LSU request accepted this cycle.
- i_hold  input  1  writeback freeze.
- o_wr  output  1  register-file write enable.
- o_rd  output  5  register-file write address.
- o_write_data  output  32  register-file write data.
- i_rs1, i_rs2  input  5 each  decode-stage read addresses (bypass only).
- o_fwd1_valid, o_fwd2_valid  output  1 each  forward hit (bypass only).
- o_fwd1_data, o_fwd2_data  output  32 each  forwarded data (bypass only).

Function
REQ-002 A request SHALL be accepted in a cycle when its valid and its ready are both high; ready SHALL be combinational from valid, i_hold, rst and the priority pointer.
REQ-003 At most one request SHALL be accepted per cycle, and no request SHALL be accepted while i_hold or rst is high.
REQ-004 If only one requester is valid and i_hold is low, that requester SHALL be accepted.
REQ-005 If both are valid, the requester not granted most recently SHALL win (round-robin); the loser's ready SHALL stay low and it SHALL hold its request.
REQ-006 The priority pointer SHALL update only on acceptance, to favour the other requester next.
REQ-007 An accepted request SHALL appear on o_rd/o_write_data with o_wr high on the following cycle (latency 1); sustained throughput SHALL be one write per cycle.
REQ-008 An accepted request with rd = 0 SHALL be consumed; o_wr SHALL be low in its output cycle.
REQ-009 o_wr SHALL be high for exactly one cycle per accepted nonzero-rd request, except as held under REQ-010.
REQ-010 While i_hold is high, the output register SHALL retain its contents and o_wr SHALL be low; a write pending at hold entry SHALL be issued in the first cycle after i_hold falls, and no new acceptance SHALL occur in that same cycle.
REQ-011 When no write is issued, o_rd and o_write_data SHALL keep their last values.

Reset
REQ-012 While rst is high: o_wr = 0, o_rd = 0, o_write_data = 0, both readies = 0, pointer = ALU-first, any pending or held write discarded.
REQ-013 Reset asserted mid-operation SHALL take effect at the next clock edge, with no write issued after that edge.

Configuration
REQ-014 With macro WB_BYPASS_EN defined, o_fwdN_valid SHALL be high when i_rsN is nonzero and equals the rd of the write currently driven or held in the output register; o_fwdN_data SHALL then equal that write's data (combinational).
REQ-015 If WB_BYPASS_EN is defined and no forward hit exists, o_fwdN_valid SHALL be 0 and o_fwdN_data SHALL be 0.
REQ-016 Without WB_BYPASS_EN, i_rs1, i_rs2 and all o_fwd* ports SHALL be absent.

Verification
REQ-017 ALU-only: alu rd=5, data=0xDEADBEEF -> ready same cycle; next cycle o_wr=1, o_rd=5, o_write_data=0xDEADBEEF.
REQ-018 Contention after reset: both valid (alu rd=3/0x11, lsu rd=4/0x22) for 2 cycles -> ALU written first, LSU second, o_wr high in 2 consecutive cycles.
REQ-019 Zero rd: lsu rd=0, data=0x55 -> lsu ready=1; o_wr stays 0.
REQ-020 Hold: accept alu rd=7/0x77, then i_hold=1 for 3 cycles -> o_wr=0 throughout; write rd=7/0x77 issued in the cycle after i_hold falls.
REQ-021 Reset mid-operation: accept rd=9 then assert rst at the next edge -> no write to rd=9; all outputs 0.
REQ-022 Bypass (WB_BYPASS_EN): output holds rd=12/0xCAFE and i_rs1=12, i_rs2=0 -> o_fwd1_valid=1, o_fwd1_data=0xCAFE, o_fwd2_valid=0.
